// File: rtl/display_time_ctrl.sv
// Clock-face time keeper: BCD HH:MM:SS, time-set mode, frame-synchronous display
// shadow with edit blinking, hourly-chime and alarm indicators. Single VGA_CLK domain.
module display_time_ctrl #(
  parameter int             P_BLINK_FRAMES  = 30,
  parameter int             P_HOURLY_FRAMES = 120,
  parameter int             P_ALARM_FRAMES  = 600,
  parameter logic [7:0]     P_ALARM_HH      = 8'h07,
  parameter logic [7:0]     P_ALARM_MM      = 8'h00
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        FRAME_START,
  input  logic        SEC_TICK,
  input  logic        KEY_MODE,
  input  logic        KEY_NEXT,
  input  logic        KEY_INC,
  output logic [23:0] NUMBER_BCD,
  output logic [5:0]  NUMBER_ENABLE,
  output logic        HOURLY,
  output logic        ALARM,
  output logic        EDIT_ACTIVE
);

  localparam int BLINK_W  = (P_BLINK_FRAMES  > 1) ? $clog2(P_BLINK_FRAMES)  : 1;
  localparam int HOURLY_W = (P_HOURLY_FRAMES > 1) ? $clog2(P_HOURLY_FRAMES) : 1;
  localparam int ALARM_W  = (P_ALARM_FRAMES  > 1) ? $clog2(P_ALARM_FRAMES)  : 1;
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(P_BLINK_FRAMES - 1);
  localparam logic [HOURLY_W-1:0] HOURLY_LAST = HOURLY_W'(P_HOURLY_FRAMES - 1);
  localparam logic [ALARM_W-1:0]  ALARM_LAST  = ALARM_W'(P_ALARM_FRAMES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, EDIT_HH = 2'd1, EDIT_MM = 2'd2, EDIT_SS = 2'd3} state_t;

  // Per-nibble BCD increment wrapping from 'last' back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      bcd_inc = 8'h00;
    else if (v[3:0] == 4'h9)
      bcd_inc = {v[7:4] + 4'h1, 4'h0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'h1};
  endfunction

  state_t              state_r;
  logic [7:0]          hh_r, mm_r, ss_r;
  logic [BLINK_W-1:0]  blink_cnt_r;
  logic                blink_phase_r;
  logic [HOURLY_W-1:0] hourly_cnt_r;
  logic [ALARM_W-1:0]  alarm_cnt_r;
  logic                hourly_r, alarm_r, edit_active_r;
  logic [23:0]         number_bcd_r;
  logic [5:0]          number_enable_r;

  logic [7:0] ss_tick_s, mm_tick_s, hh_tick_s;
  logic       run_tick_s, hourly_hit_s, alarm_hit_s;
  logic       enter_edit_s, next_act_s, any_key_s;
  logic [5:0] enable_s;

  // Tick successor of the working time plus decoded key/flag events.
  always_comb begin
    ss_tick_s    = bcd_inc(ss_r, 8'h59);
    mm_tick_s    = (ss_r == 8'h59) ? bcd_inc(mm_r, 8'h59) : mm_r;
    hh_tick_s    = (ss_r == 8'h59 && mm_r == 8'h59) ? bcd_inc(hh_r, 8'h23) : hh_r;
    run_tick_s   = (state_r == RUN) && SEC_TICK;
    hourly_hit_s = (mm_tick_s == 8'h00) && (ss_tick_s == 8'h00);
    alarm_hit_s  = (hh_tick_s == P_ALARM_HH) && (mm_tick_s == P_ALARM_MM) && (ss_tick_s == 8'h00);
    enter_edit_s = (state_r == RUN) && KEY_MODE;
    next_act_s   = (state_r != RUN) && !KEY_MODE && KEY_NEXT;
    any_key_s    = KEY_MODE || KEY_NEXT || KEY_INC;
  end

  // Digit enables: the edited field follows the blink phase, everything else lit.
  always_comb begin
    enable_s = 6'h3F;
    case (state_r)
      RUN:     enable_s = 6'h3F;
      EDIT_HH: enable_s = {blink_phase_r, blink_phase_r, 4'hF};
      EDIT_MM: enable_s = {2'b11, blink_phase_r, blink_phase_r, 2'b11};
      EDIT_SS: enable_s = {4'hF, blink_phase_r, blink_phase_r};
      default: enable_s = 6'h3F;
    endcase
  end

  // Mode FSM, working time, blink/flag counters and frame-synchronous display shadow.
  always_ff @(posedge VGA_CLK) begin
    if (!RST_N) begin
      state_r         <= RUN;
      hh_r            <= 8'h00;
      mm_r            <= 8'h00;
      ss_r            <= 8'h00;
      blink_cnt_r     <= '0;
      blink_phase_r   <= 1'b1;
      hourly_cnt_r    <= '0;
      alarm_cnt_r     <= '0;
      hourly_r        <= 1'b0;
      alarm_r         <= 1'b0;
      edit_active_r   <= 1'b0;
      number_bcd_r    <= 24'h000000;
      number_enable_r <= 6'h3F;
    end else begin
      case (state_r)
        RUN: begin
          if (SEC_TICK) begin
            hh_r <= hh_tick_s;
            mm_r <= mm_tick_s;
            ss_r <= ss_tick_s;
          end
          if (KEY_MODE) begin
            state_r       <= EDIT_HH;
            edit_active_r <= 1'b1;
          end
        end
        EDIT_HH: begin
          if (KEY_MODE) begin
            state_r       <= RUN;
            edit_active_r <= 1'b0;
          end else if (KEY_NEXT) state_r <= EDIT_MM;
          else if (KEY_INC)      hh_r    <= bcd_inc(hh_r, 8'h23);
        end
        EDIT_MM: begin
          if (KEY_MODE) begin
            state_r       <= RUN;
            edit_active_r <= 1'b0;
          end else if (KEY_NEXT) state_r <= EDIT_SS;
          else if (KEY_INC)      mm_r    <= bcd_inc(mm_r, 8'h59);
        end
        EDIT_SS: begin
          if (KEY_MODE) begin
            state_r       <= RUN;
            edit_active_r <= 1'b0;
          end else if (KEY_NEXT) state_r <= EDIT_HH;
          else if (KEY_INC)      ss_r    <= bcd_inc(ss_r, 8'h59);
        end
        default: begin
          state_r       <= RUN;
          edit_active_r <= 1'b0;
        end
      endcase

      if (enter_edit_s || next_act_s) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= 1'b1;
      end else if (FRAME_START) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
      end

      // A fresh trigger outranks frame counting; entering edit silences both flags.
      if (enter_edit_s) begin
        hourly_r     <= 1'b0;
        hourly_cnt_r <= '0;
      end else if (run_tick_s && hourly_hit_s) begin
        hourly_r     <= 1'b1;
        hourly_cnt_r <= '0;
      end else if (FRAME_START && hourly_r) begin
        if (hourly_cnt_r == HOURLY_LAST) begin
          hourly_r     <= 1'b0;
          hourly_cnt_r <= '0;
        end else begin
          hourly_cnt_r <= hourly_cnt_r + HOURLY_W'(1);
        end
      end

      if (enter_edit_s) begin
        alarm_r     <= 1'b0;
        alarm_cnt_r <= '0;
      end else if (run_tick_s && alarm_hit_s) begin
        alarm_r     <= 1'b1;
        alarm_cnt_r <= '0;
      end else if (any_key_s) begin
        alarm_r     <= 1'b0;
        alarm_cnt_r <= '0;
      end else if (FRAME_START && alarm_r) begin
        if (alarm_cnt_r == ALARM_LAST) begin
          alarm_r     <= 1'b0;
          alarm_cnt_r <= '0;
        end else begin
          alarm_cnt_r <= alarm_cnt_r + ALARM_W'(1);
        end
      end

      if (FRAME_START) begin
        number_bcd_r    <= {hh_r, mm_r, ss_r};
        number_enable_r <= enable_s;
      end
    end
  end

  assign NUMBER_BCD    = number_bcd_r;
  assign NUMBER_ENABLE = number_enable_r;
  assign HOURLY        = hourly_r;
  assign ALARM         = alarm_r;
  assign EDIT_ACTIVE   = edit_active_r;

endmodule
